instr_loader: RTL

Program-buffer and fetch sequencer that sits directly upstream of `cpu`. It captures a program byte-serially from the chip input pins into a 16-entry buffer. On `start` it replays the program into `cpu`'s `INSTRUCTION` and `write_en` inputs, one byte per cycle, honouring a stall. It makes the TT02 tile programmable without an external memory.

---
 rtl/loader_pkg.sv | 13 +
 rtl/instr_loader_if.sv | 21 ++
 rtl/instr_loader_mem.sv | 21 ++
 rtl/instr_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding and buffer geometry.
package loader_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/instr_loader_if.sv
// Load/playback bus between the program source, the loader and the cpu instruction port.
interface instr_loader_if #(
  parameter int DW = 8
);
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          start;
  logic          stall;
  logic [DW-1:0] INSTRUCTION;
  logic          write_en;

  modport master (
    output load_valid, load_data, start, stall,
    input  INSTRUCTION, write_en
  );

  modport slave (
    input  load_valid, load_data, start, stall,
    output INSTRUCTION, write_en
  );
endinterface

// File: rtl/instr_loader_mem.sv
// Program buffer: synchronous write, combinational read, contents deliberately not reset.
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_loader.sv
// Captures a byte-serial program into a small buffer and replays it into the cpu, one byte per unstalled cycle.
module instr_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  instr_loader_if.slave bus,
  output logic [AW:0]   prog_len,
  output logic [1:0]    state,
  output logic          done,
  output logic          overflow
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state_q, state_n;
  logic [AW:0]   len_q, len_n;
  logic [AW-1:0] rd_q, rd_n;
  logic          ovf_q, ovf_n;
  logic [DW-1:0] instr_p0, instr_n;
  logic          vld_p0, vld_n;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_rdata;
  logic          last_issue;

  instr_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.load_data),
    .raddr (rd_q),
    .rdata (mem_rdata)
  );

  assign last_issue = ({1'b0, rd_q} == (len_q - ONE));

  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    rd_n      = rd_q;
    ovf_n     = ovf_q;
    instr_n   = instr_p0;
    vld_n     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = len_q[AW-1:0];
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          len_n     = ONE;
          state_n   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A byte arriving with start still joins the program before playback begins.
        if (bus.load_valid) begin
          if (len_q < FULL) begin
            mem_we = 1'b1;
            len_n  = len_q + ONE;
          end else begin
            ovf_n = 1'b1;
          end
        end
        if (bus.start) begin
          rd_n    = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          instr_n = mem_rdata;
          vld_n   = 1'b1;
          rd_n    = rd_q + 1'b1;
          if (last_issue) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          len_n     = ONE;
          ovf_n     = 1'b0;
          state_n   = ST_LOAD;
        end else if (bus.start) begin
          rd_n    = '0;
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Issue stage: registered instruction/valid toward the cpu
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      state_q  <= state_n;
      len_q    <= len_n;
      rd_q     <= rd_n;
      ovf_q    <= ovf_n;
      instr_p0 <= instr_n;
      vld_p0   <= vld_n;
    end
  end

  assign bus.INSTRUCTION = instr_p0;
  assign bus.write_en    = vld_p0;
  assign prog_len        = len_q;
  assign state           = state_q;
  assign done            = (state_q == ST_DONE);
  assign overflow        = ovf_q;
endmodule
